// File: rtl/w_route_ctrl.sv
// w_route_ctrl: steers W beats from per-master FIFOs to one slave port in AW-grant order.
// Define W_ROUTE_STATS_EN to add burst_cnt, a saturating count of completed bursts.
module w_route_ctrl #(
  parameter int NUM_MASTERS = 4,
  parameter int ORDER_DEPTH = 8,
  parameter int MID_WIDTH   = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   aw_push,
  input  logic [MID_WIDTH-1:0]   aw_mid,
  output logic                   aw_order_full,
  input  logic [NUM_MASTERS-1:0] w_empty,
  input  logic [NUM_MASTERS-1:0] w_front_last,
  output logic [NUM_MASTERS-1:0] w_pop,
  output logic [MID_WIDTH-1:0]   w_sel,
  output logic                   WVALID,
  input  logic                   WREADY
`ifdef W_ROUTE_STATS_EN
  ,
  output logic [15:0]            burst_cnt
`endif
);
  localparam int PTR_W = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
  localparam int CNT_W = $clog2(ORDER_DEPTH) + 1;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t                 state_r;
  logic [MID_WIDTH-1:0]   cur_mid_r;
  logic [MID_WIDTH-1:0]   order_mem_r [ORDER_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [CNT_W-1:0]       count_r;

  logic                   full_s;
  logic                   enq_s;
  logic                   deq_s;
  logic                   wvalid_s;
  logic                   hs_s;
  logic                   last_hs_s;
  logic [NUM_MASTERS-1:0] sel_oh_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(ORDER_DEPTH - 1)) begin
      return '0;
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  // One-hot decode of cur_mid; an out-of-range index selects nobody, so that burst never shows WVALID.
  always_comb begin
    sel_oh_s = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      sel_oh_s[i] = (cur_mid_r == MID_WIDTH'(i));
    end
  end

  assign full_s    = (count_r == CNT_W'(ORDER_DEPTH));
  assign enq_s     = aw_push & ~full_s;
  assign deq_s     = (state_r == IDLE) & (count_r != '0);
  assign wvalid_s  = (state_r == BURST) & |(sel_oh_s & ~w_empty);
  assign hs_s      = wvalid_s & WREADY;
  assign last_hs_s = hs_s & |(sel_oh_s & w_front_last);

  assign aw_order_full = full_s;
  assign w_sel         = cur_mid_r;
  assign WVALID        = wvalid_s;
  assign w_pop         = sel_oh_s & {NUM_MASTERS{hs_s}};

  // Order storage; no reset needed because count gates every read.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      order_mem_r[wr_ptr_r] <= aw_mid;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (deq_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Burst FSM: the head is latched in IDLE, so a new burst always follows a one-cycle bubble.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r   <= IDLE;
      cur_mid_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (deq_s) begin
            cur_mid_r <= order_mem_r[rd_ptr_r];
            state_r   <= BURST;
          end
        end
        BURST: begin
          if (last_hs_s) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

`ifdef W_ROUTE_STATS_EN
  logic [15:0] burst_cnt_r;

  // Completed-burst counter, sticks at all-ones.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      burst_cnt_r <= 16'h0000;
    end else if (last_hs_s && (burst_cnt_r != 16'hFFFF)) begin
      burst_cnt_r <= burst_cnt_r + 16'h0001;
    end
  end

  assign burst_cnt = burst_cnt_r;
`endif

endmodule

// File: tb/tb_w_route_ctrl.sv
// Bench for w_route_ctrl: directed vector tables for ordering/full/stall/reset corners,
// then randomized traffic against a queue-based reference model.
module tb_w_route_ctrl;
  localparam int NM    = 4;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       aw_push = 1'b0;
  logic [1:0] aw_mid = 2'd0;
  logic       aw_order_full;
  logic [3:0] w_empty = 4'b1111;
  logic [3:0] w_front_last = 4'b0000;
  logic [3:0] w_pop;
  logic [1:0] w_sel;
  logic       WVALID;
  logic       WREADY = 1'b0;
`ifdef W_ROUTE_STATS_EN
  logic [15:0] burst_cnt;
`endif

  int checks = 0;
  int errors = 0;

  w_route_ctrl #(.NUM_MASTERS(NM), .ORDER_DEPTH(DEPTH), .MID_WIDTH(2)) dut (
    .clk(clk), .nrst(nrst), .aw_push(aw_push), .aw_mid(aw_mid),
    .aw_order_full(aw_order_full), .w_empty(w_empty), .w_front_last(w_front_last),
    .w_pop(w_pop), .w_sel(w_sel), .WVALID(WVALID), .WREADY(WREADY)
`ifdef W_ROUTE_STATS_EN
    , .burst_cnt(burst_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       push;
    logic [1:0] mid;
    logic [3:0] empty;
    logic [3:0] last;
    logic       ready;
    logic       exp_wv;
    logic [3:0] exp_pop;
    logic [1:0] exp_sel;
    logic       exp_full;
  } vec_t;

  vec_t order_tbl [12];

  function automatic vec_t v(input logic push, input logic [1:0] mid, input logic [3:0] empty,
                             input logic [3:0] last, input logic ready, input logic exp_wv,
                             input logic [3:0] exp_pop, input logic [1:0] exp_sel,
                             input logic exp_full);
    vec_t t;
    t.push = push; t.mid = mid; t.empty = empty; t.last = last; t.ready = ready;
    t.exp_wv = exp_wv; t.exp_pop = exp_pop; t.exp_sel = exp_sel; t.exp_full = exp_full;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at negedge and compare outputs before the next posedge.
  task automatic apply(input string tag, input int idx, input vec_t t);
    @(negedge clk);
    aw_push = t.push; aw_mid = t.mid; w_empty = t.empty;
    w_front_last = t.last; WREADY = t.ready;
    #1;
    chk($sformatf("%s[%0d].wvalid", tag, idx), 32'(WVALID), 32'(t.exp_wv));
    chk($sformatf("%s[%0d].w_pop", tag, idx), 32'(w_pop), 32'(t.exp_pop));
    chk($sformatf("%s[%0d].w_sel", tag, idx), 32'(w_sel), 32'(t.exp_sel));
    chk($sformatf("%s[%0d].full", tag, idx), 32'(aw_order_full), 32'(t.exp_full));
  endtask

  // Assert reset with W data available on every master; outputs must be quiet at once.
  task automatic do_reset(input string tag);
    @(negedge clk);
    aw_push = 1'b0; w_empty = 4'b0000; w_front_last = 4'b1111; WREADY = 1'b1;
    nrst = 1'b0;
    #1;
    chk({tag, ".wvalid"}, 32'(WVALID), 32'd0);
    chk({tag, ".w_pop"}, 32'(w_pop), 32'd0);
    chk({tag, ".w_sel"}, 32'(w_sel), 32'd0);
    chk({tag, ".full"}, 32'(aw_order_full), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  // Single-beat burst on master 3 from an idle, empty queue; sel_before is the prior cur_mid.
  task automatic one_beat(input string tag, input logic [1:0] sel_before);
    apply(tag, 0, v(1'b1, 2'd3, 4'b0000, 4'b1000, 1'b1, 1'b0, 4'b0000, sel_before, 1'b0));
    apply(tag, 1, v(1'b0, 2'd0, 4'b0000, 4'b1000, 1'b1, 1'b0, 4'b0000, sel_before, 1'b0));
    apply(tag, 2, v(1'b0, 2'd0, 4'b0000, 4'b1000, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b0));
    apply(tag, 3, v(1'b0, 2'd0, 4'b0000, 4'b1000, 1'b1, 1'b0, 4'b0000, 2'd3, 1'b0));
    apply(tag, 4, v(1'b0, 2'd0, 4'b0000, 4'b1000, 1'b1, 1'b0, 4'b0000, 2'd3, 1'b0));
  endtask

  // Reference model state: queued grants, plus the burst currently owning the port.
  int  mq[$];
  bit  act;
  int  cur;

  initial begin
    // Ordering: mid 2 then mid 0, 4 beats each, one bubble between.
    order_tbl[0]  = v(1'b1, 2'd2, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);
    order_tbl[1]  = v(1'b1, 2'd0, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);
    order_tbl[2]  = v(1'b0, 2'd0, 4'b0000, 4'b0001, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b0);
    order_tbl[3]  = v(1'b0, 2'd0, 4'b0000, 4'b0001, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b0);
    order_tbl[4]  = v(1'b0, 2'd0, 4'b0000, 4'b0001, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b0);
    order_tbl[5]  = v(1'b0, 2'd0, 4'b0000, 4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b0);
    order_tbl[6]  = v(1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd2, 1'b0);
    order_tbl[7]  = v(1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0);
    order_tbl[8]  = v(1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0);
    order_tbl[9]  = v(1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0);
    order_tbl[10] = v(1'b0, 2'd0, 4'b0000, 4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0);
    order_tbl[11] = v(1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);

    do_reset("rst0");
    for (int i = 0; i < 12; i++) apply("order", i, order_tbl[i]);
    one_beat("beat1", 2'd0);

`ifdef W_ROUTE_STATS_EN
    @(negedge clk);
    chk("stats.three", 32'(burst_cnt), 32'd3);
    force dut.burst_cnt_r = 16'hFFFE;
    @(negedge clk);
    release dut.burst_cnt_r;
    one_beat("sat1", 2'd3);
    one_beat("sat2", 2'd3);
    @(negedge clk);
    chk("stats.saturate", 32'(burst_cnt), 32'h0000FFFF);
`endif

    // Full: the first grant is taken into a burst, so nine pushes fill the eight entries.
    do_reset("rst1");
    for (int i = 0; i < 9; i++) begin
      apply("full", i, v(1'b1, 2'((i + 1) % 4), 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000,
                         (i < 2) ? 2'd0 : 2'd1, 1'b0));
    end
    apply("full", 9,  v(1'b1, 2'd3, 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b1));
    apply("full", 10, v(1'b0, 2'd0, 4'b1101, 4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1));
    apply("full", 11, v(1'b0, 2'd0, 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b1));
    apply("full", 12, v(1'b0, 2'd0, 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd2, 1'b0));

    // Stall: WREADY toggling and master 1 running dry while others have data.
    do_reset("rst2");
    apply("stall", 0, v(1'b1, 2'd1, 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0));
    apply("stall", 1, v(1'b0, 2'd0, 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0));
    apply("stall", 2, v(1'b0, 2'd0, 4'b1101, 4'b0000, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0));
    apply("stall", 3, v(1'b0, 2'd0, 4'b1101, 4'b0000, 1'b0, 1'b1, 4'b0000, 2'd1, 1'b0));
    apply("stall", 4, v(1'b0, 2'd0, 4'b0010, 4'b0001, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b0));
    apply("stall", 5, v(1'b0, 2'd0, 4'b0010, 4'b0001, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0));
    apply("stall", 6, v(1'b0, 2'd0, 4'b0010, 4'b0010, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b0));
    apply("stall", 7, v(1'b0, 2'd0, 4'b1101, 4'b0010, 1'b0, 1'b1, 4'b0000, 2'd1, 1'b0));
    apply("stall", 8, v(1'b0, 2'd0, 4'b1101, 4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0));
    apply("stall", 9, v(1'b0, 2'd0, 4'b1101, 4'b0010, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b0));

    // Reset after beat 2 of 4 with another grant queued; nothing stale may survive.
    do_reset("rst3");
    apply("midrst", 0, v(1'b1, 2'd2, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0));
    apply("midrst", 1, v(1'b1, 2'd1, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0));
    apply("midrst", 2, v(1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b0));
    apply("midrst", 3, v(1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b0));
    do_reset("rst4");
    for (int i = 0; i < 3; i++) begin
      apply("post", i, v(1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0));
    end
    apply("post", 3, v(1'b1, 2'd0, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0));
    apply("post", 4, v(1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0));
    apply("post", 5, v(1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0));
    apply("post", 6, v(1'b0, 2'd0, 4'b0000, 4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0));
    apply("post", 7, v(1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0));

    // Randomized traffic against the queue model; push-heavy phases exercise full.
    do_reset("rst5");
    mq.delete();
    act = 1'b0;
    cur = 0;
    for (int n = 0; n < 4000; n++) begin
      bit         exp_full;
      bit         exp_wv;
      logic [3:0] exp_pop;
      int         qn;
      @(negedge clk);
      aw_push = ($urandom_range(0, 99) < (((n / 500) % 2 == 1) ? 85 : 30));
      aw_mid  = 2'($urandom_range(0, 3));
      w_empty = 4'($urandom) & 4'($urandom);
      for (int b = 0; b < NM; b++) w_front_last[b] = ($urandom_range(0, 2) == 0);
      WREADY  = ($urandom_range(0, 3) != 0);
      #1;
      exp_full = (mq.size() == DEPTH);
      exp_wv   = act && !w_empty[cur];
      exp_pop  = (exp_wv && WREADY) ? 4'(32'd1 << cur) : 4'b0000;
      chk($sformatf("rand[%0d].wvalid", n), 32'(WVALID), 32'(exp_wv));
      chk($sformatf("rand[%0d].w_pop", n), 32'(w_pop), 32'(exp_pop));
      chk($sformatf("rand[%0d].w_sel", n), 32'(w_sel), 32'(cur));
      chk($sformatf("rand[%0d].full", n), 32'(aw_order_full), 32'(exp_full));
      @(posedge clk);
      qn = mq.size();
      if (!act && qn > 0) begin
        cur = mq.pop_front();
        act = 1'b1;
      end else if (act && exp_wv && WREADY && w_front_last[cur]) begin
        act = 1'b0;
      end
      if (aw_push && qn < DEPTH) mq.push_back(int'(aw_mid));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
